// File: rtl/cpu_control_fsm_if.sv
// Control-unit <-> datapath bundle: instruction opcode and ALU status in,
// program counter, datapath controls and status out.
interface cpu_control_fsm_if;
    logic [3:0]  opcode;
    logic        zero;
    logic [15:0] branch_offset;
    logic [15:0] pc;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [1:0]  alu_op;
    logic        halted;
    logic        illegal_op;
    logic [15:0] instr_count;
    logic [2:0]  state;

    modport master (
        input  opcode, zero, branch_offset,
        output pc, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, alu_op, halted, illegal_op, instr_count, state
    );

    modport slave (
        output opcode, zero, branch_offset,
        input  pc, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, alu_op, halted, illegal_op, instr_count, state
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU: owns the PC, sequences one
// instruction at a time through FETCH/DECODE/EXEC/MEM/WB and drives datapath controls.
module cpu_control_fsm #(
    parameter logic [15:0] PC_STEP  = 16'd2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    cpu_control_fsm_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1100;
    localparam logic [3:0] OP_BEQ   = 4'b1101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [3:0]  r_opcode;
    logic [15:0] r_instr_count;
    ctrl_t       r_ctrl;
    logic        r_halted;

    logic        w_defined;
    logic [15:0] w_pc_seq;
    logic [15:0] w_pc_retire;

    // Control word to present while sitting in state s for opcode op.
    function automatic ctrl_t ctrl_for(state_t s, logic [3:0] op);
        ctrl_t c;
        c = '0;
        if (s inside {S_EXEC, S_MEM, S_WB}) begin
            case (op)
                OP_RTYPE:     begin c.reg_dst = 1'b1; c.alu_op = 2'b10; end
                OP_ADDI:      begin c.alu_src = 1'b1; c.alu_op = 2'b11; end
                OP_LW, OP_SW: begin c.alu_src = 1'b1; c.alu_op = 2'b00; end
                OP_BEQ:       begin c.alu_op = 2'b01; c.branch = (s == S_EXEC); end
                default:      c = '0;
            endcase
            c.reg_write  = (s == S_WB);
            c.mem_read   = (op == OP_LW) && (s inside {S_MEM, S_WB});
            c.mem_to_reg = (op == OP_LW) && (s == S_WB);
            c.mem_write  = (op == OP_SW) && (s == S_MEM);
        end
        return c;
    endfunction

    assign w_defined = bus.opcode inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT};
    assign w_pc_seq  = r_pc + PC_STEP;

    // Only a BEQ retiring from EXEC with Zero set takes the branch target.
    assign w_pc_retire = (r_state == S_EXEC && r_opcode == OP_BEQ && bus.zero)
                         ? w_pc_seq + bus.branch_offset : w_pc_seq;

    // NOTE: every register here updates with <= so all next-state logic sees
    // the pre-edge values, independent of statement order inside the block.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_opcode      <= '0;
            r_instr_count <= '0;
            r_ctrl        <= '0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_state <= S_DECODE;
                    r_ctrl  <= '0;
                end
                S_DECODE: begin
                    r_opcode <= bus.opcode;
                    if (bus.opcode == OP_HALT) begin
                        r_state       <= S_HALT;
                        r_instr_count <= r_instr_count + 16'd1;
                        r_halted      <= 1'b1;
                        r_ctrl        <= '0;
                    end else if (w_defined) begin
                        r_state <= S_EXEC;
                        r_ctrl  <= ctrl_for(S_EXEC, bus.opcode);
                    end else begin
                        r_state <= S_FETCH;
                        r_pc    <= w_pc_seq;
                        r_ctrl  <= '0;
                    end
                end
                S_EXEC: begin
                    case (r_opcode)
                        OP_RTYPE, OP_ADDI: begin
                            r_state <= S_WB;
                            r_ctrl  <= ctrl_for(S_WB, r_opcode);
                        end
                        OP_LW, OP_SW: begin
                            r_state <= S_MEM;
                            r_ctrl  <= ctrl_for(S_MEM, r_opcode);
                        end
                        default: begin
                            r_state       <= S_FETCH;
                            r_pc          <= w_pc_retire;
                            r_instr_count <= r_instr_count + 16'd1;
                            r_ctrl        <= '0;
                        end
                    endcase
                end
                S_MEM: begin
                    if (r_opcode == OP_LW) begin
                        r_state <= S_WB;
                        r_ctrl  <= ctrl_for(S_WB, r_opcode);
                    end else begin
                        r_state       <= S_FETCH;
                        r_pc          <= w_pc_retire;
                        r_instr_count <= r_instr_count + 16'd1;
                        r_ctrl        <= '0;
                    end
                end
                S_WB: begin
                    r_state       <= S_FETCH;
                    r_pc          <= w_pc_retire;
                    r_instr_count <= r_instr_count + 16'd1;
                    r_ctrl        <= '0;
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                    r_ctrl   <= '0;
                end
                default: begin
                    r_state  <= S_FETCH;
                    r_halted <= 1'b0;
                    r_ctrl   <= '0;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.reg_dst     = r_ctrl.reg_dst;
    assign bus.alu_src     = r_ctrl.alu_src;
    assign bus.mem_to_reg  = r_ctrl.mem_to_reg;
    assign bus.reg_write   = r_ctrl.reg_write;
    assign bus.mem_read    = r_ctrl.mem_read;
    assign bus.mem_write   = r_ctrl.mem_write;
    assign bus.branch      = r_ctrl.branch;
    assign bus.alu_op      = r_ctrl.alu_op;
    assign bus.halted      = r_halted;
    assign bus.instr_count = r_instr_count;
    assign bus.state       = r_state;

    // Decoded from the live opcode so the pulse lands in the DECODE cycle itself.
    assign bus.illegal_op  = (r_state == S_DECODE) && !w_defined;

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multi-cycle control unit and program counter sequencer for the 16-bit CPU datapath.
- Owns the PC register and decodes the 4-bit opcode (Instruction[15:12]).
- Drives the datapath control inputs RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, AluOp and Branch, one instruction at a time.
- Samples the ALU Zero flag to resolve BEQ, and exposes halt, illegal-opcode and retired-instruction status.

Parameters:
- PC_STEP, 2: PC increment per sequential instruction.
- RESET_PC, 16'h0000: PC value after reset.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Opcode  in  4  Instruction[15:12] from instruction memory (combinational from PC).
- Zero  in  1  ALU zero flag from the datapath.
- BranchOffset  in  16  sign-extended, pre-scaled branch offset from the datapath.
- PC  out  16  current program counter.
- RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls.
- AluOp  out  2  ALU control class.
- Halted  out  1  high while in HALT.
- IllegalOp  out  1  one-cycle pulse on an undefined opcode.
- InstrCount  out  16  retired-instruction counter.
- State  out  3  debug copy of the FSM state.

Behaviour:
- Clocking and reset:
  - Reset is synchronous and active-high; single clock.
  - Reset has priority over everything, including mid-instruction and HALT.
  - On reset: PC=RESET_PC, State=FETCH, InstrCount=0, opcode latch=0, all controls 0, Halted=0, IllegalOp=0.
  - A write enable asserted in the cycle of reset has no effect after reset.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to FETCH.
- FETCH:
  - Instruction memory settles on PC; all controls 0.
  - Next state DECODE.
- DECODE:
  - Latch Opcode into the internal opcode register. All later states use the latched value, never the live input.
  - Defined opcodes: 0000 R-type, 0100 ADDI, 1000 LW, 1100 SW, 1101 BEQ, 1111 HALT.
  - Defined non-HALT opcode: next state EXEC.
  - HALT: next state HALT.
  - Any other opcode: IllegalOp=1 for this cycle, PC<=PC+PC_STEP, InstrCount unchanged, next state FETCH.
- Control values, held constant from EXEC through the last state of the instruction (all 0 in FETCH, DECODE and HALT):
  - R-type: RegDst=1, AluSrc=0, AluOp=10.
  - ADDI: RegDst=0, AluSrc=1, AluOp=11.
  - LW and SW: AluSrc=1, AluOp=00.
  - BEQ: AluSrc=0, AluOp=01, Branch=1 in EXEC only.
- State sequence and strobes per opcode:
  - R-type and ADDI: EXEC -> WB. RegWrite=1 only in WB.
  - LW: EXEC -> MEM -> WB. MemRead=1 in MEM and WB; MemToReg=1 and RegWrite=1 in WB only.
  - SW: EXEC -> MEM. MemWrite=1 in MEM only; MEM is the last state.
  - BEQ: EXEC is the last state. Sample Zero in EXEC:
    - Zero=1: PC<=PC+PC_STEP+BranchOffset (16-bit arithmetic, wraps modulo 2^16).
    - Zero=0: PC<=PC+PC_STEP.
- Retirement, on the rising edge ending an instruction's last state:
  - PC advances (branch target for a taken BEQ).
  - InstrCount increments by 1, wrapping 16'hFFFF -> 0.
  - Next state FETCH.
- Latencies: R-type and ADDI 4 cycles; LW 5; SW 4; BEQ 3; illegal opcode 2.
- HALT:
  - Entered from DECODE. Counts as retired: InstrCount+1 on entry; PC unchanged.
  - Halted=1, all controls 0; stays until Reset.
- PC wrap: PC+PC_STEP overflow wraps silently, no flag.
- The PC register is the only PC source; the datapath PC input is driven from this output.

Test Plan:
- Reset, then R-type at PC=0 -> State sequence 0,1,2,4,0. RegDst=1, AluOp=10 in cycles 2-3; RegWrite=1 only in cycle 3; PC=2 and InstrCount=1 after cycle 3.
- LW then SW -> LW: MemRead=1 for 2 cycles, MemToReg and RegWrite in WB, 5 cycles total. SW: MemWrite=1 for exactly 1 cycle, never RegWrite, 4 cycles. PC 0->2->4.
- BEQ at PC=16'h0010, BranchOffset=16'h0008: Zero=1 -> PC=16'h001A; Zero=0 -> PC=16'h0012. Branch=1 only in EXEC.
- BEQ at PC=16'hFFFE, BranchOffset=16'h0004, Zero=1 -> PC=16'h0004 (wrap). Opcode 0011 -> one IllegalOp pulse, PC+2, InstrCount unchanged.
- Opcode changed on the input during EXEC -> controls follow the latched opcode only. HALT -> Halted=1, PC frozen, InstrCount+1, no strobes for 20 cycles.
- Reset asserted in the MEM state of SW (MemWrite=1) -> next cycle State=0, PC=0, all controls 0. InstrCount preset near 16'hFFFF wraps to 0 after one more retirement.
